wb_line_fetch: RTL and testbench
================================

# wb_line_fetch

Wishbone read master that sits directly upstream of the 16-bit SRAM controller and streams a block of consecutive 32-bit words into a local first-word-fall-through FIFO. A client (display scanout, DMA, CPU-side prefetch) programs a base address and word count, pulses `start`, and pops words at its own pace. The block issues single-word read cycles only, never page-mode cycles, and throttles itself on FIFO occupancy.

## Interface
- `adr_width`, 18: SRAM address width of the downstream controller; the byte address space is 2^(adr_width-1).
- `fifo_aw`, 4: FIFO address bits; depth = 2^fifo_aw words.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; ignored while `busy`.
- `fetch_base`  in  32  byte address of first word; bits [1:0] ignored.
- `fetch_len`  in  16  number of 32-bit words to fetch.
- `abort`  in  1  terminate the current fetch after any in-flight cycle completes.
- `busy`  out  1  fetch in progress.
- `done`  out  1  one-cycle pulse at the end of a fetch, whether completed or aborted.
- `wb_cyc_o`, `wb_stb_o`  out  1  Wishbone cycle/strobe; always driven equal.
- `wb_we_o`  out  1  constant 0.
- `wb_sel_o`  out  4  constant 4'b1111.
- `wb_adr_o`  out  32  word-aligned byte address.
- `wb_dat_i`  in  32  read data.
- `wb_ack_i`  in  1  cycle acknowledge.
- `fifo_rd`  in  1  pop head word.
- `fifo_dat`  out  32  head word; 0 while `fifo_empty`.
- `fifo_empty`  out  1  FIFO holds no words.
- `fifo_level`  out  fifo_aw+1  words currently held.

## Operation
- States: IDLE, REQ, GAP.
- IDLE, `start`=1:
  - Flush the FIFO.
  - Latch address = `fetch_base` with bits [1:0] and [31:adr_width-1] cleared.
  - Latch remaining = `fetch_len`.
  - If `fetch_len`=0: pulse `done` and stay in IDLE.
  - Otherwise set `busy` and go to GAP.
- GAP:
  - Go to REQ when remaining>0, `fifo_level` < depth and `abort`=0.
  - Go to IDLE with `done` when remaining=0 or `abort`=1.
  - Otherwise wait.
- REQ:
  - `cyc`/`stb` are high and held until `wb_ack_i`.
  - On ack, in the same edge: push `wb_dat_i`, add 4 to the address, decrement remaining, drop `cyc`/`stb`, go to GAP.
- Only one cycle is outstanding at a time. The level check in GAP reserves the slot, so a push never meets a full FIFO.
- The GAP cycle guarantees `stb` is low for at least one cycle after each ack. The controller clears its ack only in its idle state, so `stb` must not be re-asserted while ack is high.
- Address forcing:
  - Bit adr_width-1 of `wb_adr_o` is held at 0, so the controller never enters page mode.
  - The address wraps from 2^(adr_width-1)-4 to 0.
- `abort` is sampled in REQ and in GAP.
  - A started Wishbone cycle is never abandoned; the block waits for its ack, pushes the word, then ends via GAP.
  - Words already in the FIFO are kept.
- FIFO rules:
  - `fifo_rd` while empty is ignored.
  - Push and pop in the same cycle leave the level unchanged; push into an empty FIFO with a simultaneous pop is not a pop.
  - Read and write pointers wrap modulo depth.
- `start` while `busy` is ignored, including in the cycle `done` is asserted.

## Timing
- Reset values: `busy`=0, `done`=0, `wb_cyc_o`=`wb_stb_o`=0, `wb_adr_o`=0, `fifo_level`=0, `fifo_empty`=1, `fifo_dat`=0. Constant outputs hold their constants during reset.
- `start` at edge 0: `busy`=1 after edge 0; `cyc`/`stb` first high after edge 1.
- Ack at edge N:
  - Word visible on `fifo_dat` and `fifo_empty`=0 after edge N.
  - `stb` is low for the cycle after edge N.
  - Next `stb` rises after edge N+1 at the earliest.
  - Peak rate is one word per (controller latency + 2) cycles.
- Final ack at edge N: `done`=1 and `busy`=0 after edge N+1; `done` lasts exactly one cycle.
- Asynchronous `reset` mid-cycle:
  - All outputs drop to their reset values immediately and the FIFO empties.
  - The controller is reset by the same signal.

## Test plan
- `fetch_base`=0x100, `fetch_len`=3, ack 2 cycles after each `stb` rise -> addresses 0x100/0x104/0x108 in order; 3 words in FIFO in order; `done` one cycle after 3rd ack; `stb` low ≥1 cycle between requests.
- `fetch_len`=40, depth 16, no pops -> exactly 16 reads issued, then `stb` stays low with `fifo_level`=16. Popping one word -> exactly one further read.
- `fetch_base`=2^(adr_width-1)-8, `fetch_len`=4 -> addresses wrap to 0 then 4; `wb_adr_o`[adr_width-1] never 1.
- `abort` asserted in REQ, ack held off 5 cycles -> `stb` held until ack, word pushed, `done` next-but-one cycle, no further `stb`.
- Simultaneous push and `fifo_rd` at level 1, plus `fifo_rd` on empty -> level stays 1, then 0, never underflows; `fifo_dat`=0 while empty.
- `reset` pulsed while `stb`=1 -> `cyc`/`stb`/`busy` low immediately, `fifo_empty`=1; a fresh `start` works normally.

Source files
------------

// File: rtl/wb_line_fetch.sv
// Wishbone read master that streams a block of consecutive 32-bit words from the SRAM
// controller into a local first-word-fall-through FIFO, one single-word cycle at a time.
module wb_line_fetch #(
    parameter int adr_width = 18,
    parameter int fifo_aw   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        fetch_base,
    input  logic [15:0]        fetch_len,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic               wb_we_o,
    output logic [3:0]         wb_sel_o,
    output logic [31:0]        wb_adr_o,
    input  logic [31:0]        wb_dat_i,
    input  logic               wb_ack_i,
    input  logic               fifo_rd,
    output logic [31:0]        fifo_dat,
    output logic               fifo_empty,
    output logic [fifo_aw:0]   fifo_level
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;

    localparam int depth = 1 << fifo_aw;
    // Keeps bits [adr_width-2:2]: word aligned, page-mode bit held low, wraps at the top.
    localparam logic [31:0] adr_mask = 32'((64'd1 << (adr_width - 1)) - 64'd4);
    localparam logic [fifo_aw:0]   full_level = {1'b1, {fifo_aw{1'b0}}};
    localparam logic [fifo_aw:0]   level_one  = 1;
    localparam logic [fifo_aw-1:0] ptr_one    = 1;

    logic [1:0]  state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [15:0] rem_q, rem_d;
    logic        abort_q, abort_d;
    logic        done_q, done_d;
    logic        flush, push, pop;

    logic [31:0]        mem [depth];
    logic [fifo_aw-1:0] wptr_q, rptr_q;
    logic [fifo_aw:0]   level_q, level_d;

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        rem_d   = rem_q;
        abort_d = abort_q;
        done_d  = 1'b0;
        flush   = 1'b0;
        push    = 1'b0;
        case (state_q)
            StIdle: begin
                // A start coinciding with the done pulse belongs to the previous fetch.
                if (start && !done_q) begin
                    flush   = 1'b1;
                    adr_d   = fetch_base & adr_mask;
                    rem_d   = fetch_len;
                    abort_d = 1'b0;
                    if (fetch_len == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (rem_q == 16'd0 || abort || abort_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (level_q < full_level) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (abort) begin
                    abort_d = 1'b1;
                end
                if (wb_ack_i) begin
                    push    = 1'b1;
                    adr_d   = (adr_q + 32'd4) & adr_mask;
                    rem_d   = rem_q - 16'd1;
                    state_d = StGap;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pop = fifo_rd && (level_q != '0);

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + level_one;
            2'b01:   level_d = level_q - level_one;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            adr_q   <= '0;
            rem_q   <= '0;
            abort_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            rem_q   <= rem_d;
            abort_q <= abort_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + ptr_one;
            end
            if (pop) begin
                rptr_q <= rptr_q + ptr_one;
            end
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= wb_dat_i;
        end
    end

    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign wb_cyc_o   = (state_q == StReq);
    assign wb_stb_o   = (state_q == StReq);
    assign wb_we_o    = 1'b0;
    assign wb_sel_o   = 4'b1111;
    assign wb_adr_o   = adr_q;
    assign fifo_empty = (level_q == '0);
    assign fifo_level = level_q;
    assign fifo_dat   = fifo_empty ? 32'd0 : mem[rptr_q];

endmodule

// File: tb/tb_wb_line_fetch.sv
// Bench for wb_line_fetch: Wishbone slave with programmable latency, a queue-based
// reference model compared every cycle, and directed scenarios with literal expectations.
module tb_wb_line_fetch;

    localparam int AW    = 18;
    localparam int FAW   = 4;
    localparam int DEPTH = 16;
    localparam logic [31:0] ADR_SPAN = 32'h0002_0000;
    localparam logic [31:0] KEY      = 32'h5A00_0000;

    logic        clk = 1'b0;
    logic        reset, start, abort, fifo_rd, wb_ack_i;
    logic [31:0] fetch_base, wb_dat_i;
    logic [15:0] fetch_len;
    logic        busy, done, wb_cyc_o, wb_stb_o, wb_we_o, fifo_empty;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o, fifo_dat;
    logic [FAW:0] fifo_level;

    int n_checks = 0;
    int n_fails  = 0;

    wb_line_fetch #(.adr_width(AW), .fifo_aw(FAW)) dut (
        .clk(clk), .reset(reset), .start(start), .fetch_base(fetch_base),
        .fetch_len(fetch_len), .abort(abort), .busy(busy), .done(done),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .fifo_rd(fifo_rd),
        .fifo_dat(fifo_dat), .fifo_empty(fifo_empty), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Wishbone slave: acks `lat` cycles after strobe rises, ack lasts one cycle.
    int lat = 2;
    initial begin
        int scnt;
        scnt = 0;
        wb_ack_i = 1'b0;
        wb_dat_i = '0;
        forever begin
            @(negedge clk);
            if (reset || wb_ack_i) begin
                wb_ack_i = 1'b0;
                scnt = 0;
            end else if (wb_stb_o) begin
                if (scnt >= lat - 1) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = wb_adr_o ^ KEY;
                    scnt = 0;
                end else begin
                    scnt++;
                end
            end else begin
                scnt = 0;
            end
        end
    end

    // Reference model: FIFO as a queue, fetch as counters and flags.
    logic [31:0] q[$];
    bit          m_busy, m_stb, m_done, m_abt;
    int          m_rem;
    logic [31:0] m_adr;
    initial begin
        bit do_pop, was_done;
        int lvl;
        m_busy = 0; m_stb = 0; m_done = 0; m_abt = 0; m_rem = 0; m_adr = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                q.delete();
                m_busy = 0; m_stb = 0; m_done = 0; m_abt = 0; m_rem = 0; m_adr = '0;
            end else begin
                lvl      = q.size();
                do_pop   = fifo_rd && (lvl > 0);
                was_done = m_done;
                m_done   = 0;
                if (do_pop) void'(q.pop_front());
                if (!m_busy) begin
                    if (start && !was_done) begin
                        q.delete();
                        m_adr = (fetch_base & ~32'd3) % ADR_SPAN;
                        if (fetch_len == 16'd0) begin
                            m_done = 1;
                        end else begin
                            m_busy = 1;
                            m_rem  = int'(fetch_len);
                            m_abt  = 0;
                        end
                    end
                end else if (m_stb) begin
                    if (abort) m_abt = 1;
                    if (wb_ack_i) begin
                        q.push_back(wb_dat_i);
                        m_adr = (m_adr + 32'd4) % ADR_SPAN;
                        m_rem--;
                        m_stb = 0;
                    end
                end else begin
                    if (m_rem == 0 || abort || m_abt) begin
                        m_busy = 0;
                        m_done = 1;
                    end else if (lvl < DEPTH) begin
                        m_stb = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison and request logging.
    logic [31:0] adr_log[$];
    int          rd_cnt = 0;
    int          done_cnt = 0;
    initial begin
        bit prev_stb;
        prev_stb = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                prev_stb = 0;
            end else begin
                check("busy", busy, m_busy);
                check("done", done, m_done);
                check("stb", wb_stb_o, m_stb);
                check("cyc", wb_cyc_o, m_stb);
                check("adr", wb_adr_o, m_adr);
                check("empty", fifo_empty, q.size() == 0);
                check("level", fifo_level, q.size());
                check("fifo_dat", fifo_dat, q.size() > 0 ? q[0] : 32'd0);
                check("we", wb_we_o, 0);
                check("sel", wb_sel_o, 4'hF);
                if (wb_stb_o) check("adr_page_bit", wb_adr_o[AW-1], 0);
                if (wb_stb_o && !prev_stb) begin
                    adr_log.push_back(wb_adr_o);
                    rd_cnt++;
                end
                if (done) done_cnt++;
                prev_stb = wb_stb_o;
            end
        end
    end

    task automatic do_start(input logic [31:0] base, input logic [15:0] len);
        @(negedge clk);
        start = 1'b1;
        fetch_base = base;
        fetch_len = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int base_cnt, input int max_cyc, input string name);
        for (int i = 0; i < max_cyc; i++) begin
            if (done_cnt != base_cnt) return;
            @(negedge clk);
        end
        check(name, 32'(done_cnt != base_cnt), 1);
    endtask

    task automatic wait_stb(input int max_cyc, input string name);
        for (int i = 0; i < max_cyc; i++) begin
            if (wb_stb_o) return;
            @(negedge clk);
        end
        check(name, wb_stb_o, 1);
    endtask

    task automatic pop_check(input string name, input logic [31:0] exp);
        check(name, fifo_dat, exp);
        fifo_rd = 1'b1;
        @(negedge clk);
        fifo_rd = 1'b0;
    endtask

    task automatic log_check(input string name, input int idx, input logic [31:0] exp);
        check(name, idx < adr_log.size() ? adr_log[idx] : 32'hDEAD_DEAD, exp);
    endtask

    initial begin
        int d0, r0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; fifo_rd = 1'b0;
        fetch_base = '0; fetch_len = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_level", fifo_level, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_dat", fifo_dat, 0);
        check("rst_sel", wb_sel_o, 4'hF);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Basic three-word fetch; start during the done cycle must be ignored.
        lat = 2; adr_log.delete(); d0 = done_cnt;
        do_start(32'h100, 16'd3);
        wait_done(d0, 100, "t1_done");
        r0 = rd_cnt;
        start = 1'b1; fetch_base = 32'h900; fetch_len = 16'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("t1_start_in_done_ignored", busy, 0);
        check("t1_no_extra_req", rd_cnt - r0, 0);
        check("t1_nreq", adr_log.size(), 3);
        log_check("t1_adr0", 0, 32'h100);
        log_check("t1_adr1", 1, 32'h104);
        log_check("t1_adr2", 2, 32'h108);
        pop_check("t1_w0", 32'h5A00_0100);
        pop_check("t1_w1", 32'h5A00_0104);
        pop_check("t1_w2", 32'h5A00_0108);
        check("t1_drained", fifo_empty, 1);

        // FIFO full throttling, one pop releases exactly one more read, abort in GAP.
        lat = 1; r0 = rd_cnt;
        do_start(32'h0, 16'd40);
        repeat (120) @(negedge clk);
        check("t2_nreq_full", rd_cnt - r0, 16);
        check("t2_level_full", fifo_level, 16);
        check("t2_stb_idle", wb_stb_o, 0);
        fifo_rd = 1'b1;
        @(negedge clk);
        fifo_rd = 1'b0;
        repeat (20) @(negedge clk);
        check("t2_nreq_after_pop", rd_cnt - r0, 17);
        check("t2_level_refill", fifo_level, 16);
        d0 = done_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(d0, 20, "t2_done");
        check("t2_words_kept", fifo_level, 16);
        check("t2_head", fifo_dat, 32'h5A00_0004);

        // Zero-length start: flushes, pulses done, stays idle.
        repeat (2) @(negedge clk);
        d0 = done_cnt; r0 = rd_cnt;
        do_start(32'h10, 16'd0);
        wait_done(d0, 5, "t0_done");
        check("t0_flushed", fifo_level, 0);
        check("t0_idle", busy, 0);
        check("t0_no_req", rd_cnt - r0, 0);

        // Address masking and wrap at the top of the address space.
        repeat (2) @(negedge clk);
        lat = 2; adr_log.delete(); d0 = done_cnt;
        do_start(32'hABCF_FFF9, 16'd4);
        wait_done(d0, 100, "t3_done");
        check("t3_nreq", adr_log.size(), 4);
        log_check("t3_adr0", 0, 32'h1_FFF8);
        log_check("t3_adr1", 1, 32'h1_FFFC);
        log_check("t3_adr2", 2, 32'h0);
        log_check("t3_adr3", 3, 32'h4);
        pop_check("t3_w0", 32'h5A01_FFF8);
        pop_check("t3_w1", 32'h5A01_FFFC);
        pop_check("t3_w2", 32'h5A00_0000);
        pop_check("t3_w3", 32'h5A00_0004);

        // Abort during a slow cycle: the cycle completes and its word is kept.
        repeat (2) @(negedge clk);
        lat = 6; r0 = rd_cnt; d0 = done_cnt;
        do_start(32'h200, 16'd5);
        wait_stb(20, "t4_stb_seen");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(d0, 50, "t4_done");
        repeat (10) @(negedge clk);
        check("t4_nreq", rd_cnt - r0, 1);
        check("t4_level", fifo_level, 1);
        check("t4_head", fifo_dat, 32'h5A00_0200);
        check("t4_idle", busy, 0);
        pop_check("t4_pop", 32'h5A00_0200);

        // Pop with push into empty (no pop), push+pop at level 1, pops on empty.
        repeat (2) @(negedge clk);
        lat = 2; d0 = done_cnt;
        do_start(32'h300, 16'd2);
        for (int i = 0; i < 40 && done_cnt == d0; i++) begin
            @(negedge clk);
            #1;
            fifo_rd = wb_ack_i;
        end
        fifo_rd = 1'b0;
        check("t5_done", 32'(done_cnt != d0), 1);
        check("t5_level", fifo_level, 1);
        check("t5_head", fifo_dat, 32'h5A00_0304);
        fifo_rd = 1'b1;
        repeat (3) @(negedge clk);
        fifo_rd = 1'b0;
        check("t5_level_empty", fifo_level, 0);
        check("t5_empty", fifo_empty, 1);
        check("t5_dat_zero", fifo_dat, 0);

        // Asynchronous reset in the middle of a strobe, then a fresh fetch.
        repeat (2) @(negedge clk);
        lat = 4;
        do_start(32'h400, 16'd4);
        wait_stb(20, "t6_stb_seen");
        #2 reset = 1'b1;
        #1;
        check("t6_stb", wb_stb_o, 0);
        check("t6_cyc", wb_cyc_o, 0);
        check("t6_busy", busy, 0);
        check("t6_empty", fifo_empty, 1);
        check("t6_level", fifo_level, 0);
        check("t6_adr", wb_adr_o, 0);
        @(negedge clk);
        reset = 1'b0;
        lat = 1; adr_log.delete(); d0 = done_cnt;
        do_start(32'h500, 16'd2);
        wait_done(d0, 50, "t6_done");
        check("t6_nreq", adr_log.size(), 2);
        log_check("t6_adr0", 0, 32'h500);
        log_check("t6_adr1", 1, 32'h504);
        pop_check("t6_w0", 32'h5A00_0500);
        pop_check("t6_w1", 32'h5A00_0504);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

endmodule
